cabac_bin_sched: RTL and testbench

// Round-robin scheduler that shares one CABAC bin engine among NREQ syntax-element parsers.

---
 rtl/cabac_bin_sched.sv | 169 ++++++++++++++++
 tb/tb_cabac_bin_sched.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cabac_bin_sched.sv
// cabac_bin_sched: round-robin arbiter sharing one CABAC bin engine among NREQ syntax-element parsers,
// sequencing slice init, 2-cycle context decodes and 1-cycle bypass/terminate decodes.
module cabac_bin_sched #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_slice_start,
    input  logic              i_bs_rdy,
    input  logic [NREQ-1:0]   i_req,
    input  logic [2*NREQ-1:0] i_req_kind,
    input  logic [3*NREQ-1:0] i_req_cls,
    input  logic [6*NREQ-1:0] i_req_cm,
    input  logic              i_init_done,
    input  logic              i_valid,
    input  logic              i_bin_cu,
    input  logic              i_bin_sd,
    input  logic              i_bin_xy_pref,
    input  logic              i_bin_sig,
    input  logic              i_bin_gt1_etc,
    input  logic              i_bin_byp,
    input  logic              i_bin_term,
    output logic              o_en,
    output logic              o_init,
    output logic              o_dec_en_cu,
    output logic              o_dec_en_sd,
    output logic              o_dec_en_xy_pref,
    output logic              o_dec_en_sig,
    output logic              o_dec_en_gt1_etc,
    output logic [4:0]        o_cm_idx_cu,
    output logic [2:0]        o_cm_idx_sd,
    output logic [5:0]        o_cm_idx_xy_pref,
    output logic [5:0]        o_cm_idx_sig,
    output logic [5:0]        o_cm_idx_gt1_etc,
    output logic              o_byp_en,
    output logic              o_term_en,
    output logic [NREQ-1:0]   o_ack,
    output logic              o_bin,
    output logic              o_slice_end,
    output logic              o_busy,
    output logic              o_err
);
    localparam int PW = $clog2(NREQ);

    typedef enum logic [2:0] {IDLE, INIT, WAIT_INIT, READY, CTX0, CTX1, SGL} state_t;

    state_t          state, nxt;
    logic [PW-1:0]   ptr, gnt, g, idx;
    logic            gnt_vld, illegal, ctx_act, done_ctx, done_sgl, ctx_bin, sgl_bin;
    logic [1:0]      kind;
    logic [2:0]      cls;
    logic [5:0]      cm;
    logic [NREQ-1:0] req_m;
    logic [7:0]      ctx_bins;
    logic [1:0]      kinds [NREQ];
    logic [2:0]      clss  [NREQ];
    logic [5:0]      cms   [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_fields
        assign kinds[i] = i_req_kind[2*i +: 2];
        assign clss[i]  = i_req_cls[3*i +: 3];
        assign cms[i]   = i_req_cm[6*i +: 6];
    end

    // the requester being acked this cycle still holds i_req; mask it so it is not regranted
    assign req_m = i_req & ~o_ack;

    always_comb begin
        gnt_vld = 1'b0;
        gnt     = '0;
        idx     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr) + k) % NREQ);
            if (req_m[idx]) begin
                gnt_vld = 1'b1;
                gnt     = idx;
            end
        end
    end

    assign illegal  = kinds[gnt] == 2'd3 || clss[gnt] > 3'd4;
    assign ctx_bins = {3'b000, i_bin_gt1_etc, i_bin_sig, i_bin_xy_pref, i_bin_sd, i_bin_cu};
    assign ctx_bin  = ctx_bins[cls];
    assign sgl_bin  = kind == 2'd2 ? i_bin_term : i_bin_byp;
    assign done_ctx = state == CTX1 && i_bs_rdy && i_valid;
    assign done_sgl = state == SGL && i_bs_rdy;

    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:      nxt = IDLE;
            INIT:      nxt = WAIT_INIT;
            WAIT_INIT: nxt = i_init_done ? READY : WAIT_INIT;
            READY:     nxt = !gnt_vld || illegal ? READY : kinds[gnt] == 2'd0 ? CTX0 : SGL;
            CTX0:      nxt = i_bs_rdy ? CTX1 : CTX0;
            CTX1:      nxt = done_ctx ? READY : CTX1;
            SGL:       nxt = !done_sgl ? SGL : kind == 2'd2 && i_bin_term ? IDLE : READY;
            default:   nxt = IDLE;
        endcase
        if (i_slice_start)
            nxt = INIT;
    end

    always_comb begin
        ctx_act          = state == CTX0 || state == CTX1;
        o_init           = state == INIT;
        o_busy           = state != READY;
        o_en             = i_bs_rdy && (ctx_act || state == SGL);
        o_dec_en_cu      = ctx_act && cls == 3'd0;
        o_dec_en_sd      = ctx_act && cls == 3'd1;
        o_dec_en_xy_pref = ctx_act && cls == 3'd2;
        o_dec_en_sig     = ctx_act && cls == 3'd3;
        o_dec_en_gt1_etc = ctx_act && cls == 3'd4;
        o_cm_idx_cu      = o_dec_en_cu ? cm[4:0] : '0;
        o_cm_idx_sd      = o_dec_en_sd ? cm[2:0] : '0;
        o_cm_idx_xy_pref = o_dec_en_xy_pref ? cm : '0;
        o_cm_idx_sig     = o_dec_en_sig ? cm : '0;
        o_cm_idx_gt1_etc = o_dec_en_gt1_etc ? cm : '0;
        o_byp_en         = state == SGL && kind == 2'd1;
        o_term_en        = state == SGL && kind == 2'd2;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr         <= '0;
            g           <= '0;
            kind        <= '0;
            cls         <= '0;
            cm          <= '0;
            o_ack       <= '0;
            o_bin       <= 1'b0;
            o_slice_end <= 1'b0;
            o_err       <= 1'b0;
        end else begin
            o_ack       <= '0;
            o_bin       <= 1'b0;
            o_slice_end <= 1'b0;
            if (!i_slice_start) begin
                if (state == READY && gnt_vld) begin
                    g    <= gnt;
                    kind <= kinds[gnt];
                    cls  <= clss[gnt];
                    cm   <= cms[gnt];
                    ptr  <= gnt == PW'(NREQ - 1) ? '0 : gnt + 1'b1;
                    if (illegal) begin
                        o_ack <= NREQ'(1) << gnt;
                        o_err <= 1'b1;
                    end
                end
                if (done_ctx) begin
                    o_ack <= NREQ'(1) << g;
                    o_bin <= ctx_bin;
                end
                if (done_sgl) begin
                    o_ack       <= NREQ'(1) << g;
                    o_bin       <= sgl_bin;
                    o_slice_end <= kind == 2'd2 && i_bin_term;
                end
            end
        end
    end
endmodule

// File: tb/tb_cabac_bin_sched.sv
// tb_cabac_bin_sched: directed stimulus with a scoreboard queue of expected acks
// (vector, bin, slice_end, cycle) checked by an independent monitor.
module tb_cabac_bin_sched;
    localparam int NREQ = 4;

    logic clk = 1'b0, rst_n = 1'b0, i_slice_start = 1'b0, i_bs_rdy = 1'b1;
    logic [NREQ-1:0]   i_req = '0;
    logic [2*NREQ-1:0] i_req_kind = '0;
    logic [3*NREQ-1:0] i_req_cls = '0;
    logic [6*NREQ-1:0] i_req_cm = '0;
    logic i_init_done = 0, i_valid = 0, i_bin_cu = 0, i_bin_sd = 0, i_bin_xy_pref = 0;
    logic i_bin_sig = 0, i_bin_gt1_etc = 0, i_bin_byp = 0, i_bin_term = 0;
    logic o_en, o_init, o_dec_en_cu, o_dec_en_sd, o_dec_en_xy_pref, o_dec_en_sig, o_dec_en_gt1_etc;
    logic [4:0] o_cm_idx_cu;
    logic [2:0] o_cm_idx_sd;
    logic [5:0] o_cm_idx_xy_pref, o_cm_idx_sig, o_cm_idx_gt1_etc;
    logic o_byp_en, o_term_en, o_bin, o_slice_end, o_busy, o_err;
    logic [NREQ-1:0] o_ack;

    cabac_bin_sched #(.NREQ(NREQ)) dut (
        .clk(clk), .rst_n(rst_n), .i_slice_start(i_slice_start), .i_bs_rdy(i_bs_rdy),
        .i_req(i_req), .i_req_kind(i_req_kind), .i_req_cls(i_req_cls), .i_req_cm(i_req_cm),
        .i_init_done(i_init_done), .i_valid(i_valid), .i_bin_cu(i_bin_cu), .i_bin_sd(i_bin_sd),
        .i_bin_xy_pref(i_bin_xy_pref), .i_bin_sig(i_bin_sig), .i_bin_gt1_etc(i_bin_gt1_etc),
        .i_bin_byp(i_bin_byp), .i_bin_term(i_bin_term), .o_en(o_en), .o_init(o_init),
        .o_dec_en_cu(o_dec_en_cu), .o_dec_en_sd(o_dec_en_sd), .o_dec_en_xy_pref(o_dec_en_xy_pref),
        .o_dec_en_sig(o_dec_en_sig), .o_dec_en_gt1_etc(o_dec_en_gt1_etc),
        .o_cm_idx_cu(o_cm_idx_cu), .o_cm_idx_sd(o_cm_idx_sd), .o_cm_idx_xy_pref(o_cm_idx_xy_pref),
        .o_cm_idx_sig(o_cm_idx_sig), .o_cm_idx_gt1_etc(o_cm_idx_gt1_etc),
        .o_byp_en(o_byp_en), .o_term_en(o_term_en), .o_ack(o_ack), .o_bin(o_bin),
        .o_slice_end(o_slice_end), .o_busy(o_busy), .o_err(o_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic [NREQ-1:0] ack;
        logic            bin;
        logic            se;
        int              at;
    } exp_t;
    exp_t q[$];

    task automatic chk(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int r, input logic b, input logic se, input int at);
        exp_t e;
        e.ack = NREQ'(1) << r;
        e.bin = b;
        e.se  = se;
        e.at  = at;
        q.push_back(e);
    endtask

    task automatic set_req(input int r, input logic [1:0] k, input logic [2:0] c, input logic [5:0] m);
        i_req_kind[2*r +: 2] = k;
        i_req_cls[3*r +: 3]  = c;
        i_req_cm[6*r +: 6]   = m;
    endtask

    task automatic start_slice;
        i_slice_start = 1'b1;
        tick;
        i_slice_start = 1'b0;
        tick;
        tick;
        i_init_done = 1'b1;
        tick;
        i_init_done = 1'b0;
    endtask

    task automatic reset_init;
        rst_n = 1'b0;
        i_req = '0;
        repeat (2) tick;
        rst_n = 1'b1;
        start_slice;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (o_ack != '0) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_ack: got ack=%b want none (cycle %0d)", o_ack, cyc);
            end else begin
                e = q.pop_front();
                chk("ack_vec", int'(o_ack), int'(e.ack));
                chk("ack_bin", int'(o_bin), int'(e.bin));
                chk("ack_slice_end", int'(o_slice_end), int'(e.se));
                chk("ack_cycle", cyc, e.at);
            end
        end
    end

    int t;
    int bb[5] = '{1, 0, 1, 1, 0};

    initial begin
        repeat (2) tick;
        chk("rst_busy", int'(o_busy), 1);
        chk("rst_init", int'(o_init), 0);
        chk("rst_en", int'(o_en), 0);
        chk("rst_ack", int'(o_ack), 0);
        chk("rst_err", int'(o_err), 0);
        // cycle 0: slice start; init_done in cycle 3; READY in cycle 4
        rst_n = 1'b1;
        i_slice_start = 1'b1;
        tick;
        i_slice_start = 1'b0;
        #1 chk("init_c1", int'(o_init), 1);
        tick;
        #1 chk("init_c2", int'(o_init), 0);
        tick;
        i_init_done = 1'b1;
        #1 chk("busy_c3", int'(o_busy), 1);
        tick;
        i_init_done = 1'b0;
        #1 chk("busy_c4", int'(o_busy), 0);

        // ctx decode, req0 sig class cm 17
        set_req(0, 2'd0, 3'd3, 6'd17);
        i_req = 4'b0001;
        t = cyc;
        push(0, 1'b1, 1'b0, t + 3);
        tick;
        #1 chk("ctx_dec_sig_t1", int'(o_dec_en_sig), 1);
        chk("ctx_cm_sig_t1", int'(o_cm_idx_sig), 17);
        chk("ctx_en_t1", int'(o_en), 1);
        chk("ctx_dec_cu_off", int'(o_dec_en_cu), 0);
        tick;
        i_valid = 1'b1;
        i_bin_sig = 1'b1;
        #1 chk("ctx_dec_sig_t2", int'(o_dec_en_sig), 1);
        chk("ctx_cm_sig_t2", int'(o_cm_idx_sig), 17);
        tick;
        i_valid = 1'b0;
        i_bin_sig = 1'b0;
        #1 chk("ctx_ack_busy", int'(o_busy), 0);
        chk("ctx_dec_off", int'(o_dec_en_sig), 0);
        tick;
        i_req = '0;
        #1 chk("ctx_no_regrant", int'(o_busy), 0);

        // round-robin of four bypass requesters from pointer 0
        reset_init;
        for (int r = 0; r < NREQ; r++) set_req(r, 2'd1, 3'd0, 6'd0);
        i_req = 4'b1111;
        for (int j = 0; j < 5; j++) begin
            push(j % NREQ, bb[j][0], 1'b0, cyc + 2);
            tick;
            i_bin_byp = bb[j][0];
            #1 chk("byp_en", int'(o_byp_en), 1);
            chk("byp_o_en", int'(o_en), 1);
            tick;
        end
        i_req = '0;
        i_bin_byp = 1'b0;

        // ctx decode with 3 stall cycles in CTX1; pointer now 1
        set_req(1, 2'd0, 3'd0, 6'd5);
        i_req = 4'b0010;
        t = cyc;
        push(1, 1'b0, 1'b0, t + 6);
        tick;
        #1 chk("stall_dec_cu_t1", int'(o_dec_en_cu), 1);
        tick;
        i_bs_rdy = 1'b0;
        #1 chk("stall_en_t2", int'(o_en), 0);
        chk("stall_dec_cu_t2", int'(o_dec_en_cu), 1);
        chk("stall_cm_cu_t2", int'(o_cm_idx_cu), 5);
        tick;
        #1 chk("stall_en_t3", int'(o_en), 0);
        chk("stall_dec_cu_t3", int'(o_dec_en_cu), 1);
        tick;
        i_valid = 1'b1;
        i_bin_sig = 1'b1;
        #1 chk("stall_en_t4", int'(o_en), 0);
        tick;
        i_bs_rdy = 1'b1;
        #1 chk("stall_en_t5", int'(o_en), 1);
        tick;
        i_valid = 1'b0;
        i_bin_sig = 1'b0;
        i_req = '0;

        // terminate bin 1 from req2 ends the slice; req1 stays pending
        set_req(2, 2'd2, 3'd0, 6'd0);
        set_req(1, 2'd0, 3'd0, 6'd9);
        i_req = 4'b0110;
        t = cyc;
        push(2, 1'b1, 1'b1, t + 2);
        tick;
        i_bin_term = 1'b1;
        #1 chk("term_en", int'(o_term_en), 1);
        chk("term_byp_off", int'(o_byp_en), 0);
        tick;
        #1 chk("term_busy_t2", int'(o_busy), 1);
        tick;
        #1 chk("term_busy_t3", int'(o_busy), 1);
        chk("term_no_en", int'(o_en), 0);
        chk("term_no_grant", int'(o_dec_en_cu), 0);
        i_req = '0;
        i_bin_term = 1'b0;

        // illegal kind from req1; pointer now 3
        start_slice;
        set_req(1, 2'd3, 3'd0, 6'd0);
        i_req = 4'b0010;
        push(1, 1'b0, 1'b0, cyc + 1);
        #1 chk("ill_err_before", int'(o_err), 0);
        tick;
        i_req = '0;
        #1 chk("ill_err", int'(o_err), 1);
        chk("ill_no_en", int'(o_en), 0);
        chk("ill_no_sgl", int'(o_byp_en | o_term_en), 0);
        chk("ill_busy", int'(o_busy), 0);
        tick;
        #1 chk("ill_err_sticky", int'(o_err), 1);

        // reset during CTX1; pointer now 2 so req0 is granted
        set_req(0, 2'd0, 3'd1, 6'd3);
        i_req = 4'b0001;
        tick;
        #1 chk("rmid_dec_sd", int'(o_dec_en_sd), 1);
        chk("rmid_cm_sd", int'(o_cm_idx_sd), 3);
        tick;
        rst_n = 1'b0;
        tick;
        #1 chk("rmid_en", int'(o_en), 0);
        chk("rmid_dec_sd_off", int'(o_dec_en_sd), 0);
        chk("rmid_cm_sd_off", int'(o_cm_idx_sd), 0);
        chk("rmid_err", int'(o_err), 0);
        chk("rmid_ack", int'(o_ack), 0);
        chk("rmid_busy", int'(o_busy), 1);
        rst_n = 1'b1;
        i_req = '0;
        tick;
        tick;
        chk("acks_outstanding", q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
